// File: rtl/sm_rd_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// sm_rd_scheduler_pkg
//   Shared definitions for the shared-cache read scheduler slice.
//   Holds the default geometry of the scheduler and the helper that sizes the
//   port-index field carried through the tag pipe.
//   No ports (package).
// ----------------------------------------------------------------------------
package sm_rd_scheduler_pkg;

  // Default geometry: four output ports sharing an 8-bit x 16-bit bank with a
  // three-cycle read latency.
  localparam int DEF_NUB    = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 3;

  // Width of a port index. A single-port build would still need one bit so
  // that the tag field never collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_rd_scheduler_tag_pipe.sv
// ----------------------------------------------------------------------------
// sm_tag_pipe
//   Fixed-latency valid+tag pipeline. Every read launched to memory enters
//   stage 0 together with the index of the port that owns it; the entry
//   reaches the last stage in the same cycle the memory presents the data.
//   Ports:
//     clk       in   clock
//     rst_n     in   asynchronous active-low reset, clears all valid bits
//     in_valid  in   a read is being presented to memory this cycle
//     in_tag    in   owning port index of that read
//     out_valid out  last stage holds a live read (data valid this cycle)
//     out_tag   out  owning port index of the read in the last stage
//     any_valid out  at least one stage holds a live read
// ----------------------------------------------------------------------------
module sm_tag_pipe #(
  parameter int RD_LAT = 3,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_valid
);

  logic [RD_LAT-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [RD_LAT];

  // Valid bits are the only control state: clearing them on reset is what
  // discards reads that were in flight when reset arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Tags are qualified by their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_tag   = tag_q[RD_LAT-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/sm_rd_scheduler.sv
// ----------------------------------------------------------------------------
// sm_rd_scheduler
//   Round-robin read scheduler sharing the single read port of the shared
//   cache bank among NUB switch output ports. Each cycle at most one
//   requesting port is granted; its address is issued to memory and its port
//   index travels through sm_tag_pipe for the fixed read latency, after which
//   the returned data is steered to the owning port.
//   Ports:
//     clk          in   clock
//     rst_n        in   asynchronous active-low reset
//     req          in   NUB         per-port level request, held until gnt
//     req_addr     in   NUB*ADDR_W  per-port address, port j at slice j
//     hold         in   block new grants this cycle
//     gnt          out  NUB         one-hot grant, one-cycle pulse
//     mem_rd_en    out  memory read strobe
//     mem_rd_addr  out  ADDR_W      memory read address
//     mem_rd_data  in   DATA_W      read data, valid RD_LAT cycles after strobe
//     rsp_valid    out  NUB         one-hot response strobe
//     rsp_data     out  DATA_W      response data, holds when rsp_valid=0
//     busy         out  a read is being issued or is still in flight
// ----------------------------------------------------------------------------
module sm_rd_scheduler
  import sm_rd_scheduler_pkg::*;
#(
  parameter int NUB    = DEF_NUB,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUB-1:0]        req,
  input  logic [NUB*ADDR_W-1:0] req_addr,
  input  logic                  hold,
  output logic [NUB-1:0]        gnt,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic [NUB-1:0]        rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);

  localparam int               IDX_W    = idx_width(NUB);
  localparam logic [IDX_W:0]   NUB_WIDE = (IDX_W+1)'(NUB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUB - 1);

  function automatic logic [NUB-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUB-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  issue_idx_q;
  logic [NUB-1:0]    eligible;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic              grant;
  logic [IDX_W:0]    sum;
  logic [IDX_W-1:0]  cand;
  logic [ADDR_W-1:0] addr_arr [NUB];

  logic              tag_valid;
  logic [IDX_W-1:0]  tag_idx;
  logic              tag_busy;

  // Unpack the flat address bus so the winner's address is a plain mux.
  always_comb begin
    for (int j = 0; j < NUB; j++) begin
      addr_arr[j] = req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  // Masked priority encoder. A port whose grant is visible this cycle is
  // masked so a requester that has not yet dropped req is not served twice.
  // The search starts at ptr and wraps modulo NUB; NUB need not be a power
  // of two, hence the explicit wrap on the extended sum.
  always_comb begin
    eligible  = req & ~gnt;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUB; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= NUB_WIDE) begin
        sum = sum - NUB_WIDE;
      end
      cand = sum[IDX_W-1:0];
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    grant    = win_found && !hold;
    next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  end

  // Issue registers: grant, strobe and address are presented together the
  // cycle after arbitration. The pointer only moves on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      issue_idx_q <= '0;
      ptr_q       <= '0;
    end else if (grant) begin
      gnt         <= to_onehot(win_idx);
      mem_rd_en   <= 1'b1;
      mem_rd_addr <= addr_arr[win_idx];
      issue_idx_q <= win_idx;
      ptr_q       <= next_ptr;
    end else begin
      gnt         <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      issue_idx_q <= '0;
    end
  end

  sm_tag_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (IDX_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mem_rd_en),
    .in_tag    (issue_idx_q),
    .out_valid (tag_valid),
    .out_tag   (tag_idx),
    .any_valid (tag_busy)
  );

  // Response registers: capture memory data in the cycle the owning tag
  // leaves the pipe. Data is held otherwise so consumers can sample late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_valid ? to_onehot(tag_idx) : '0;
      if (tag_valid) begin
        rsp_data <= mem_rd_data;
      end
    end
  end

  assign busy = tag_busy | mem_rd_en;

endmodule

// File: tb/tb_sm_rd_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sm_rd_scheduler
//   Self-checking bench for sm_rd_scheduler (NUB=4, ADDR_W=8, DATA_W=16,
//   RD_LAT=3). A behavioural memory answers reads after RD_LAT cycles and a
//   transaction-level model predicts every output each cycle; a table of
//   directed vectors and hand-written sequences cover the corner cases.
// ----------------------------------------------------------------------------
module tb_sm_rd_scheduler;

  localparam int NUB    = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUB-1:0]        req;
  logic [NUB*ADDR_W-1:0] req_addr;
  logic                  hold;
  logic [NUB-1:0]        gnt;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic [DATA_W-1:0]     mem_rd_data;
  logic [NUB-1:0]        rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm_rd_scheduler #(
    .NUB    (NUB),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .hold        (hold),
    .gnt         (gnt),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // Behavioural memory: returns data RD_LAT cycles after the strobe and
  // drives junk otherwise, so a mistimed capture shows up as bad data.
  logic              mem_v [RD_LAT] = '{default: 1'b0};
  logic [ADDR_W-1:0] mem_a [RD_LAT] = '{default: '0};
  logic [DATA_W-1:0] junk = '0;

  always @(posedge clk) begin
    mem_v[0] <= mem_rd_en;
    mem_a[0] <= mem_rd_addr;
    for (int k = 1; k < RD_LAT; k++) begin
      mem_v[k] <= mem_v[k-1];
      mem_a[k] <= mem_a[k-1];
    end
    junk <= DATA_W'($urandom);
  end

  assign mem_rd_data = mem_v[RD_LAT-1] ? mem_fn(mem_a[RD_LAT-1]) : junk;

  // Transaction-level reference: each grant books a response due a fixed
  // number of cycles later; busy means some booked response is outstanding.
  typedef struct {
    int                due;
    int                port;
    logic [DATA_W-1:0] data;
  } pend_t;

  pend_t             pend [$];
  int                cyc = 0;
  int                m_ptr = 0;
  logic [NUB-1:0]    m_gnt = '0;
  logic              m_rd_en = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [NUB-1:0]    m_rsp_valid = '0;
  logic [DATA_W-1:0] m_rsp_data = '0;
  logic              m_busy = 1'b0;

  task automatic model_edge();
    int winner;
    cyc++;
    if (!rst_n) begin
      m_ptr = 0; m_gnt = '0; m_rd_en = 1'b0; m_addr = '0;
      m_rsp_valid = '0; m_rsp_data = '0; m_busy = 1'b0;
      pend.delete();
      return;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      m_rsp_valid = NUB'(1 << pend[0].port);
      m_rsp_data  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      m_rsp_valid = '0;
    end
    winner = -1;
    if (!hold) begin
      for (int i = 0; i < NUB; i++) begin
        int p;
        p = (m_ptr + i) % NUB;
        if (winner < 0 && req[p] && !m_gnt[p]) winner = p;
      end
    end
    if (winner >= 0) begin
      m_gnt   = NUB'(1 << winner);
      m_rd_en = 1'b1;
      m_addr  = req_addr[winner*ADDR_W +: ADDR_W];
      m_ptr   = (winner + 1) % NUB;
      pend.push_back('{due: cyc + RD_LAT + 1, port: winner, data: mem_fn(m_addr)});
    end else begin
      m_gnt   = '0;
      m_rd_en = 1'b0;
      m_addr  = '0;
    end
    m_busy = (pend.size() != 0);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_output();
    cmp("gnt",         32'(gnt),         32'(m_gnt));
    cmp("mem_rd_en",   32'(mem_rd_en),   32'(m_rd_en));
    cmp("mem_rd_addr", 32'(mem_rd_addr), 32'(m_addr));
    cmp("rsp_valid",   32'(rsp_valid),   32'(m_rsp_valid));
    cmp("rsp_data",    32'(rsp_data),    32'(m_rsp_data));
    cmp("busy",        32'(busy),        32'(m_busy));
  endtask

  // Inputs change just after the falling edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output();
  endtask

  task automatic apply_stimulus(input logic [NUB-1:0] r, input logic h);
    req  = r;
    hold = h;
  endtask

  typedef struct {
    logic [NUB-1:0]    req;
    logic              hold;
    logic [NUB-1:0]    exp_gnt;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bool_found_blk: begin end
    // Directed arbitration vectors, starting from ptr=0 after reset.
    // Port addresses: p0=0x11, p1=0x22, p2=0x3A, p3=0x44.
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 8'h11};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0010, 8'h22};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0100, 8'h3A};
    tbl[4]  = '{4'b1111, 1'b0, 4'b1000, 8'h44};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0001, 8'h11};
    tbl[6]  = '{4'b1010, 1'b1, 4'b0000, 8'h00};
    tbl[7]  = '{4'b1010, 1'b1, 4'b0000, 8'h00};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0000, 8'h00};
    tbl[9]  = '{4'b1010, 1'b1, 4'b0000, 8'h00};
    tbl[10] = '{4'b1010, 1'b1, 4'b0000, 8'h00};
    tbl[11] = '{4'b1010, 1'b0, 4'b0010, 8'h22};
    tbl[12] = '{4'b1010, 1'b0, 4'b1000, 8'h44};
    tbl[13] = '{4'b0010, 1'b0, 4'b0010, 8'h22};
    tbl[14] = '{4'b0010, 1'b0, 4'b0000, 8'h00};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 8'h00};
    tbl[16] = '{4'b0001, 1'b0, 4'b0001, 8'h11};
    tbl[17] = '{4'b1000, 1'b0, 4'b1000, 8'h44};

    rst_n    = 1'b0;
    req      = '0;
    hold     = 1'b0;
    req_addr = {8'h44, 8'h3A, 8'h22, 8'h11};

    // Reset, then idle for 20 cycles.
    repeat (3) step();
    cmp("reset_gnt",  32'(gnt),  32'h0);
    cmp("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (20) step();

    // Table-driven arbitration: rotation, hold, masking of the granted port.
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(tbl[i].req, tbl[i].hold);
      step();
      cmp($sformatf("tbl%0d_gnt", i),  32'(gnt),         32'(tbl[i].exp_gnt));
      cmp($sformatf("tbl%0d_addr", i), 32'(mem_rd_addr), 32'(tbl[i].exp_addr));
    end
    apply_stimulus(4'b0000, 1'b0);
    repeat (RD_LAT + 3) step();

    // Single port 2 read at 0x3A: grant, address, response latency and data.
    apply_stimulus(4'b0100, 1'b0);
    lat = -1;
    for (int n = 0; n < 5; n++) begin
      step();
      if (gnt == 4'b0100) begin
        lat = 0;
        break;
      end
    end
    cmp("t2_gnt_seen", 32'(lat == 0), 32'h1);
    cmp("t2_addr", 32'(mem_rd_addr), 32'h3A);
    apply_stimulus(4'b0000, 1'b0);
    if (lat == 0) begin
      for (int n = 0; n < 10; n++) begin
        step();
        lat++;
        if (rsp_valid != '0) break;
      end
      cmp("t2_latency",   32'(lat),       32'(RD_LAT + 1));
      cmp("t2_rsp_valid", 32'(rsp_valid), 32'h4);
      cmp("t2_rsp_data",  32'(rsp_data),  32'(mem_fn(8'h3A)));
    end
    repeat (RD_LAT + 3) step();

    // Two reads in flight, then reset: nothing returns, grants restart at 0.
    apply_stimulus(4'b0011, 1'b0);
    step();
    apply_stimulus(4'b0010, 1'b0);
    step();
    apply_stimulus(4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    cmp("rst_async_gnt",  32'(gnt),  32'h0);
    cmp("rst_async_busy", 32'(busy), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (RD_LAT + 3) step();
    cmp("post_rst_busy", 32'(busy), 32'h0);
    apply_stimulus(4'b1111, 1'b0);
    step();
    cmp("post_rst_first_gnt", 32'(gnt), 32'h1);
    apply_stimulus(4'b0000, 1'b0);
    repeat (RD_LAT + 3) step();

    // Randomized traffic: requesters hold req until they see their grant.
    for (int c = 0; c < 400; c++) begin
      logic [NUB-1:0] r;
      r = req;
      for (int j = 0; j < NUB; j++) begin
        if (r[j] && gnt[j]) begin
          r[j] = 1'b0;
        end else if (!r[j] && $urandom_range(0, 2) == 0) begin
          r[j] = 1'b1;
          req_addr[j*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        end
      end
      apply_stimulus(r, $urandom_range(0, 7) == 0);
      step();
    end
    apply_stimulus(4'b0000, 1'b0);
    repeat (RD_LAT + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
